// File: rtl/checker_pkg.sv
// Shared encodings for the dual-rail result checker: FSM states, out_err
// codes and the per-rail error-code values carried on xe/ye.
package checker_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_FAILED  = 2'b10
  } fault_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_INPUT    = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_FAILED   = 2'b11;

  localparam logic [1:0] XE_OK      = 2'b00;
  localparam logic [1:0] XE_PARITY  = 2'b01;
  localparam logic [1:0] XE_ONEHOT  = 2'b10;
  localparam logic [1:0] XE_BOTH    = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_50,
  input  logic             rst_l,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk_50 or negedge rst_l) begin
    if (!rst_l)                    count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && (count != '1)) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/dual_rail_result_checker.sv
// Compares the X/Y result rails, forwards one vetted result with a status code
// and tracks rail health. Define INPUT_ERR_CNT_EN to add the in_err_count port.
module dual_rail_result_checker
  import checker_pkg::*;
#(
  parameter int DATA_W         = 3,
  parameter int CNT_W          = 8,
  parameter int MISMATCH_LIMIT = 3,
  parameter int GOOD_RUN       = 4
) (
  input  logic              clk_50,
  input  logic              rst_l,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  input  logic              xc,
  input  logic [1:0]        xe,
  input  logic [DATA_W-1:0] y,
  input  logic              yc,
  input  logic [1:0]        ye,
  input  logic              clr_fault,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic [1:0]        out_err,
  output logic [1:0]        fault_state,
`ifdef INPUT_ERR_CNT_EN
  output logic [CNT_W-1:0]  in_err_count,
`endif
  output logic              fail,
  output logic [CNT_W-1:0]  err_count
);

  localparam int SUS_W = $clog2(MISMATCH_LIMIT + 1);
  localparam int RUN_W = $clog2(GOOD_RUN + 1);
  localparam logic [SUS_W-1:0] SUS_ONE = SUS_W'(1);
  localparam logic [SUS_W-1:0] SUS_LIM = SUS_W'(MISMATCH_LIMIT);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(GOOD_RUN);

  fault_state_t     state_q;
  logic [SUS_W-1:0] sus_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic             mismatch, in_err, failed;

  // Raw-rail compare is used in every state so err_count keeps counting in FAILED.
  assign mismatch    = {x, xc, xe} != {y, yc, ye};
  assign in_err      = !mismatch && (xe != XE_OK);
  assign failed      = (state_q == ST_FAILED);
  assign fault_state = state_q;
  assign fail        = failed;

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk_50 (clk_50),
    .rst_l  (rst_l),
    .inc    (in_valid && mismatch),
    .clr    (clr_fault),
    .count  (err_count)
  );

`ifdef INPUT_ERR_CNT_EN
  sat_counter #(.WIDTH(CNT_W)) u_in_err_cnt (
    .clk_50 (clk_50),
    .rst_l  (rst_l),
    .inc    (in_valid && !failed && in_err),
    .clr    (clr_fault),
    .count  (in_err_count)
  );
`endif

  always_ff @(posedge clk_50 or negedge rst_l) begin
    if (!rst_l) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_err   <= ERR_NONE;
      state_q   <= ST_OK;
      sus_cnt   <= '0;
      run_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        if (failed) begin
          out_err <= ERR_FAILED;   out_data <= '0; out_carry <= 1'b0;
        end else if (mismatch) begin
          out_err <= ERR_MISMATCH; out_data <= '0; out_carry <= 1'b0;
        end else begin
          out_err <= in_err ? ERR_INPUT : ERR_NONE;
          out_data <= x; out_carry <= xc;
        end
      end
      // Clear wins: a coincident sample is still reported above but not counted.
      if (clr_fault) begin
        state_q <= ST_OK;
        sus_cnt <= '0;
        run_cnt <= '0;
      end else if (in_valid) begin
        case (state_q)
          ST_OK: if (mismatch) begin
            state_q <= (SUS_ONE == SUS_LIM) ? ST_FAILED : ST_SUSPECT;
            sus_cnt <= SUS_ONE;
            run_cnt <= '0;
          end
          ST_SUSPECT: if (mismatch) begin
            sus_cnt <= sus_cnt + SUS_ONE;
            run_cnt <= '0;
            if (sus_cnt + SUS_ONE == SUS_LIM) state_q <= ST_FAILED;
          end else if (run_cnt + RUN_ONE == RUN_LIM) begin
            state_q <= ST_OK;
            sus_cnt <= '0;
            run_cnt <= '0;
          end else begin
            run_cnt <= run_cnt + RUN_ONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dual_rail_result_checker.sv
// Directed table-driven bench for dual_rail_result_checker plus hand-written
// reset and saturation sequences on a second (CNT_W=2, MISMATCH_LIMIT=1) instance.
module tb_dual_rail_result_checker;

  localparam int DW = 3;
  localparam int CW = 8;
  localparam int CW2 = 2;

  logic clk_50 = 1'b0;
  logic rst_l = 1'b0;
  logic in_valid = 1'b0, in_valid2 = 1'b0;
  logic clr_fault = 1'b0, clr_fault2 = 1'b0;
  logic [DW-1:0] x = '0, y = '0;
  logic xc = 1'b0, yc = 1'b0;
  logic [1:0] xe = '0, ye = '0;

  logic          out_valid, out_carry, fail;
  logic [DW-1:0] out_data;
  logic [1:0]    out_err, fault_state;
  logic [CW-1:0] err_count;
  logic           out_valid2, out_carry2, fail2;
  logic [DW-1:0]  out_data2;
  logic [1:0]     out_err2, fault_state2;
  logic [CW2-1:0] err_count2;
`ifdef INPUT_ERR_CNT_EN
  logic [CW-1:0]  in_err_count;
  logic [CW2-1:0] in_err_count2;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk_50 = ~clk_50;

  dual_rail_result_checker #(.DATA_W(DW), .CNT_W(CW), .MISMATCH_LIMIT(3), .GOOD_RUN(4)) dut (
    .clk_50(clk_50), .rst_l(rst_l), .in_valid(in_valid),
    .x(x), .xc(xc), .xe(xe), .y(y), .yc(yc), .ye(ye), .clr_fault(clr_fault),
    .out_valid(out_valid), .out_data(out_data), .out_carry(out_carry), .out_err(out_err),
    .fault_state(fault_state),
`ifdef INPUT_ERR_CNT_EN
    .in_err_count(in_err_count),
`endif
    .fail(fail), .err_count(err_count)
  );

  dual_rail_result_checker #(.DATA_W(DW), .CNT_W(CW2), .MISMATCH_LIMIT(1), .GOOD_RUN(4)) dut2 (
    .clk_50(clk_50), .rst_l(rst_l), .in_valid(in_valid2),
    .x(x), .xc(xc), .xe(xe), .y(y), .yc(yc), .ye(ye), .clr_fault(clr_fault2),
    .out_valid(out_valid2), .out_data(out_data2), .out_carry(out_carry2), .out_err(out_err2),
    .fault_state(fault_state2),
`ifdef INPUT_ERR_CNT_EN
    .in_err_count(in_err_count2),
`endif
    .fail(fail2), .err_count(err_count2)
  );

  typedef struct {
    logic          valid, clr;
    logic [DW-1:0] x;  logic xc; logic [1:0] xe;
    logic [DW-1:0] y;  logic yc; logic [1:0] ye;
    logic          ev; logic [DW-1:0] ed; logic ec; logic [1:0] eerr;
    logic [1:0]    est; logic [7:0] ecnt; logic [7:0] eiec;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(input logic v, input logic c,
                              input int ix, input int ixc, input int ixe,
                              input int iy, input int iyc, input int iye,
                              input int ev, input int ed, input int ec, input int ee,
                              input int est, input int ecnt, input int eiec);
    vec_t r;
    r.valid = v; r.clr = c;
    r.x = DW'(ix); r.xc = ixc[0]; r.xe = 2'(ixe);
    r.y = DW'(iy); r.yc = iyc[0]; r.ye = 2'(iye);
    r.ev = ev[0]; r.ed = DW'(ed); r.ec = ec[0]; r.eerr = 2'(ee);
    r.est = 2'(est); r.ecnt = 8'(ecnt); r.eiec = 8'(eiec);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus (from posedge+1), then sample at the next posedge+1.
  task automatic drive(input logic v, input logic c,
                       input logic [DW-1:0] ix, input logic ixc, input logic [1:0] ixe,
                       input logic [DW-1:0] iy, input logic iyc, input logic [1:0] iye);
    in_valid = v; clr_fault = c;
    x = ix; xc = ixc; xe = ixe; y = iy; yc = iyc; ye = iye;
    @(posedge clk_50); #1;
  endtask

  initial begin
    string nm;
    tbl[0]  = mk(1,0, 5,1,0, 5,1,0, 1,5,1,0, 0,0,0);
    tbl[1]  = mk(0,0, 7,0,0, 0,0,0, 0,5,1,0, 0,0,0);
    tbl[2]  = mk(1,0, 3,0,2, 3,0,2, 1,3,0,1, 0,0,1);
    tbl[3]  = mk(1,0, 2,0,0, 3,0,0, 1,0,0,2, 1,1,1);
    tbl[4]  = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 1,1,1);
    tbl[5]  = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 1,1,1);
    tbl[6]  = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 1,1,1);
    tbl[7]  = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 0,1,1);
    tbl[8]  = mk(1,0, 1,1,1, 1,1,1, 1,1,1,1, 0,1,2);
    tbl[9]  = mk(1,0, 0,1,0, 0,0,0, 1,0,0,2, 1,2,2);
    tbl[10] = mk(1,0, 0,1,0, 0,0,0, 1,0,0,2, 1,3,2);
    tbl[11] = mk(1,0, 0,1,0, 0,0,0, 1,0,0,2, 2,4,2);
    tbl[12] = mk(1,0, 6,1,0, 6,1,0, 1,0,0,3, 2,4,2);
    tbl[13] = mk(1,0, 2,0,1, 2,0,0, 1,0,0,3, 2,5,2);
    tbl[14] = mk(0,1, 6,1,0, 6,1,0, 0,0,0,3, 0,0,0);
    tbl[15] = mk(1,0, 2,0,0, 3,0,0, 1,0,0,2, 1,1,0);
    tbl[16] = mk(1,1, 2,0,0, 3,0,0, 1,0,0,2, 0,0,0);
    tbl[17] = mk(1,0, 2,0,0, 3,0,0, 1,0,0,2, 1,1,0);
    tbl[18] = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 1,1,0);
    tbl[19] = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 1,1,0);
    tbl[20] = mk(1,0, 2,0,0, 3,0,0, 1,0,0,2, 1,2,0);
    tbl[21] = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 1,2,0);
    tbl[22] = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 1,2,0);
    tbl[23] = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 1,2,0);
    tbl[24] = mk(1,0, 4,0,0, 4,0,0, 1,4,0,0, 0,2,0);
    tbl[25] = mk(1,0, 2,0,0, 3,0,0, 1,0,0,2, 1,3,0);
    tbl[26] = mk(1,0, 2,0,0, 3,0,0, 1,0,0,2, 1,4,0);
    tbl[27] = mk(1,0, 2,0,0, 3,0,0, 1,0,0,2, 2,5,0);
    tbl[28] = mk(1,1, 7,1,0, 7,1,0, 1,0,0,3, 0,0,0);
    tbl[29] = mk(1,0, 7,1,0, 7,1,0, 1,7,1,0, 0,0,0);

    // Reset held with live, mismatching inputs: everything stays zero.
    in_valid = 1'b1; in_valid2 = 1'b1; x = 3'd2; y = 3'd5; xc = 1'b1;
    repeat (3) @(posedge clk_50);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_err", out_err, 0);
    check("rst_state", fault_state, 0);
    check("rst_fail", fail, 0);
    check("rst_cnt", err_count, 0);
    check("rst2_cnt", err_count2, 0);
    in_valid = 1'b0; in_valid2 = 1'b0;
    @(posedge clk_50); #1;
    rst_l = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].valid, tbl[i].clr, tbl[i].x, tbl[i].xc, tbl[i].xe,
            tbl[i].y, tbl[i].yc, tbl[i].ye);
      nm = $sformatf("v%0d", i);
      check({nm, "_valid"}, out_valid, tbl[i].ev);
      check({nm, "_data"},  out_data,  tbl[i].ed);
      check({nm, "_carry"}, out_carry, tbl[i].ec);
      check({nm, "_err"},   out_err,   tbl[i].eerr);
      check({nm, "_state"}, fault_state, tbl[i].est);
      check({nm, "_fail"},  fail, (tbl[i].est == 2'b10));
      check({nm, "_cnt"},   err_count, tbl[i].ecnt);
`ifdef INPUT_ERR_CNT_EN
      check({nm, "_iec"},   in_err_count, tbl[i].eiec);
`endif
    end

    // Asynchronous reset while in SUSPECT with a sample in flight.
    drive(1, 0, 3'd2, 0, 2'd0, 3'd3, 0, 2'd0);
    check("sus_state", fault_state, 1);
    check("sus_cnt", err_count, 1);
    in_valid = 1'b1; x = 3'd5; y = 3'd5;
    #2 rst_l = 1'b0;
    #1;
    check("arst_state", fault_state, 0);
    check("arst_valid", out_valid, 0);
    check("arst_err", out_err, 0);
    check("arst_cnt", err_count, 0);
    in_valid = 1'b0;
    @(posedge clk_50); #1;
    rst_l = 1'b1;
    drive(0, 0, 3'd5, 1, 2'd0, 3'd5, 1, 2'd0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_data", out_data, 0);
    check("post_rst_state", fault_state, 0);
    drive(1, 0, 3'd5, 1, 2'd0, 3'd5, 1, 2'd0);
    check("post_rst_clean_err", out_err, 0);
    check("post_rst_clean_data", out_data, 5);
    check("post_rst_clean_state", fault_state, 0);

    // Saturation on the narrow instance: limit 1 fails on the first mismatch.
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid2 = 1'b1; x = 3'd1; y = 3'd6; xc = 1'b0; yc = 1'b0; xe = 2'd0; ye = 2'd0;
      @(posedge clk_50); #1;
      nm = $sformatf("sat%0d", i);
      check({nm, "_cnt"}, err_count2, (i < 3) ? i + 1 : 3);
      check({nm, "_state"}, fault_state2, 2);
      check({nm, "_fail"}, fail2, 1);
      check({nm, "_err"}, out_err2, (i == 0) ? 2 : 3);
      in_valid2 = 1'b0;
      @(posedge clk_50); #1;
      check({nm, "_idle_valid"}, out_valid2, 0);
    end
    clr_fault2 = 1'b1;
    @(posedge clk_50); #1;
    clr_fault2 = 1'b0;
    check("sat_clr_state", fault_state2, 0);
    check("sat_clr_cnt", err_count2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dual_rail_result_checker.md
Name: dual_rail_result_checker

Overview:
- Downstream stage of the self-checking `main` ALU; consumes both result rails X/XC/XE and Y/YC/YE.
- Registers one result per valid cycle, compares the rails, forwards a single vetted result with a status code, and tracks rail health.
- Health tracking is a small fault state machine (OK/SUSPECT/FAILED) plus a saturating mismatch counter.
- The sticky `fail` flag drives system-level recovery.

Parameters:
- DATA_W, 3: width of the x/y result rails.
- CNT_W, 8: width of the saturating mismatch counter.
- MISMATCH_LIMIT, 3: mismatches counted in SUSPECT (including the entry one) that force FAILED.
- GOOD_RUN, 4: consecutive clean valid samples in SUSPECT that return the FSM to OK.

Ports:
- clk_50  in  1  system clock, rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- in_valid  in  1  rails carry a new result this cycle.
- x  in  DATA_W  rail-X result.
- xc  in  1  rail-X carry.
- xe  in  2  rail-X error code: 00 ok, 01 parity, 10 C not one-hot, 11 both.
- y  in  DATA_W  rail-Y result.
- yc  in  1  rail-Y carry.
- ye  in  2  rail-Y error code, same encoding as xe.
- clr_fault  in  1  synchronous clear of fault state and counters.
- out_valid  out  1  registered result valid, one-cycle pulse.
- out_data  out  DATA_W  vetted result.
- out_carry  out  1  vetted carry.
- out_err  out  2  00 good, 01 input error, 10 rail mismatch, 11 block FAILED.
- fault_state  out  2  00 OK, 01 SUSPECT, 10 FAILED.
- fail  out  1  high while fault_state == FAILED.
- err_count  out  CNT_W  total mismatches, saturating.

Behaviour:
- Reset: clock is clk_50; reset is asynchronous and active-low on rst_l. While rst_l is low, all outputs are 0, the FSM is OK, and all internal counters are 0. Reset mid-operation discards any in-flight sample.
- Latency: a sample taken on the edge with in_valid=1 appears on the next cycle with out_valid=1 for exactly one cycle. With in_valid=0, out_valid=0 and out_data/out_carry/out_err hold their previous values.
- Classification of each valid sample (first match wins):
  - FSM in FAILED -> out_err=11, data=0, carry=0.
  - {x,xc,xe} != {y,yc,ye} -> mismatch: out_err=10, data=0, carry=0.
  - xe == ye != 00 -> out_err=01, data=x, carry=xc.
  - Otherwise clean -> out_err=00, data=x, carry=xc.
- Mismatch detection uses the raw rails in every state, including FAILED.
- FSM, evaluated on valid samples only; idle cycles change nothing:
  - OK: mismatch -> SUSPECT, sus_cnt=1, run_cnt=0.
  - SUSPECT: mismatch -> sus_cnt+1 and run_cnt=0; if sus_cnt+1 == MISMATCH_LIMIT -> FAILED.
  - SUSPECT: non-mismatch sample (clean or input error) -> run_cnt+1; if run_cnt+1 == GOOD_RUN -> OK with both counters cleared.
  - FAILED: sticky until clr_fault or reset.
- err_count increments on every mismatch in any state and saturates at 2^CNT_W-1 with no wrap.
- clr_fault has priority over all counting and transitions:
  - Next state is OK; err_count, sus_cnt and run_cnt clear.
  - A sample arriving in the same cycle is still output and classified against the pre-clear state, but is not counted and causes no transition.
- Input errors (01) never change FSM state or err_count.
- MISMATCH_LIMIT=1: the first mismatch goes straight OK -> FAILED.

Optional Feature:
- Macro: INPUT_ERR_CNT_EN.
- Defined: adds port `in_err_count  out  CNT_W`, a saturating count of samples classified 01. It is cleared by clr_fault and rst_l.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package checker_pkg holds:
  - FSM state encodings (ST_OK, ST_SUSPECT, ST_FAILED).
  - out_err codes (ERR_NONE, ERR_INPUT, ERR_MISMATCH, ERR_FAILED).
  - xe/ye code constants.
- Sub-module sat_counter (WIDTH parameter; inc, clr, count ports) is used for err_count and, when INPUT_ERR_CNT_EN is defined, for in_err_count.

Test Plan:
- Reset: hold rst_l=0 with active inputs -> all outputs 0, fault_state=00. Assert rst_l=0 again while in SUSPECT -> immediate return to 0s/OK.
- Clean pass: x=y=101, xc=yc=1, xe=ye=00, in_valid=1 -> next cycle out_valid=1, out_data=101, out_carry=1, out_err=00, err_count=0.
- Input error: x=y=011, xe=ye=10 -> out_err=01, out_data=011, fault_state=00, err_count=0. With INPUT_ERR_CNT_EN defined -> in_err_count=1.
- Suspect and recover: one sample x=010, y=011 -> out_err=10, out_data=000, fault_state=01, err_count=1. Then four clean samples -> fault_state=00.
- Failure: three consecutive mismatches -> fault_state=10 and fail=1 after the third. Next clean sample -> out_err=11, out_data=000. clr_fault=1 -> fault_state=00, err_count=0. clr_fault together with a mismatch -> OK, err_count=0.
- Saturation (CNT_W=2): seven mismatches separated by idle cycles -> err_count stops at 3; fail=1.
